// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
// Handshake and data bundle for the bit-serial subtractor.
//   start_in   : request a subtraction (driven by the master)
//   A_in, B_in : minuend / subtrahend, captured when a start is accepted
//   busy_out   : high while operand bits are being processed
//   done_out   : one-cycle pulse when Diff_out/Borrow_out are fresh
//   Diff_out   : (A_in - B_in) mod 2^WIDTH, held until the next result
//   Borrow_out : final borrow, 1 when A_in < B_in (unsigned)
//   Bit_out    : current serial difference bit, meaningful while busy_out=1
// Modports: master = requester side, slave = subtractor side.
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start_in;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] Diff_out;
  logic             Borrow_out;
  logic             Bit_out;

  modport master (
    output start_in, A_in, B_in,
    input  busy_out, done_out, Diff_out, Borrow_out, Bit_out
  );

  modport slave (
    input  start_in, A_in, B_in,
    output busy_out, done_out, Diff_out, Borrow_out, Bit_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor: computes A_in - B_in LSB first, one bit
// per clock, through a single full-subtractor cell and one borrow flop.
//   clk_in   : system clock, rising-edge active
//   rst_n_in : asynchronous active-low reset
//   bus      : serial_subtractor_if slave modport (start/operands in,
//              busy/done/result/serial bit out)
// A start is accepted in IDLE or DONE; the result appears WIDTH+1 cycles
// later together with a one-cycle done pulse. Back-to-back operation from
// DONE gives one result every WIDTH+1 cycles.
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  serial_subtractor_if.slave bus
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Full-subtractor difference bit.
  function automatic logic fs_diff(input logic a, input logic b, input logic bor);
    return a ^ b ^ bor;
  endfunction

  // Full-subtractor borrow-out.
  function automatic logic fs_borrow(input logic a, input logic b, input logic bor);
    return (~a & b) | (~(a ^ b) & bor);
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] sh_a_r;
  logic [WIDTH-1:0] sh_b_r;
  // Only the first WIDTH-1 difference bits need storing; the last bit goes
  // straight into diff_r on the final edge.
  logic [WIDTH-2:0] res_r;
  logic [WIDTH-2:0] res_next_s;
  logic             bor_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;

  logic             accept_s;
  logic             last_s;
  logic             d_s;
  logic             bor_next_s;

  // Bit cell on the current LSBs and borrow, plus the next result shift.
  always_comb begin
    d_s        = fs_diff(sh_a_r[0], sh_b_r[0], bor_r);
    bor_next_s = fs_borrow(sh_a_r[0], sh_b_r[0], bor_r);
    res_next_s = (WIDTH-1)'({d_s, res_r} >> 1);
  end

  // Next-state logic and start acceptance.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start_in) begin
          state_next_s = ST_RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = ST_DONE;
          last_s       = 1'b1;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.start_in) begin
          state_next_s = ST_RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand shifters, borrow flop, bit counter and held result.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sh_a_r   <= {WIDTH{1'b0}};
      sh_b_r   <= {WIDTH{1'b0}};
      res_r    <= {(WIDTH-1){1'b0}};
      bor_r    <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
    end else if (accept_s) begin
      sh_a_r <= bus.A_in;
      sh_b_r <= bus.B_in;
      res_r  <= {(WIDTH-1){1'b0}};
      bor_r  <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else if (state_r == ST_RUN) begin
      sh_a_r <= sh_a_r >> 1;
      sh_b_r <= sh_b_r >> 1;
      res_r  <= res_next_s;
      bor_r  <= bor_next_s;
      if (last_s) begin
        // Counter parks on its last value so it never exceeds WIDTH-1,
        // whatever WIDTH is.
        diff_r   <= {d_s, res_r};
        borrow_r <= bor_next_s;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign bus.busy_out   = (state_r == ST_RUN);
  assign bus.done_out   = (state_r == ST_DONE);
  assign bus.Diff_out   = diff_r;
  assign bus.Borrow_out = borrow_r;
  // Serial bit is forced low outside RUN so idle shifters never leak out.
  assign bus.Bit_out    = (state_r == ST_RUN) ? d_s : 1'b0;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Directed bench for serial_subtractor (WIDTH=8). A timeline model tracks
// which cycle of an operation the block is in and derives every expected
// output from plain arithmetic on the captured operands; a compare process
// checks it on every falling edge. Directed tests add literal expectations.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  serial_subtractor_if #(.WIDTH(W)) bus_if ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // m_phase: 0 = idle, 1..W = serial bit m_phase-1 in flight, W+1 = done.
  int           m_phase = 0;
  logic [W-1:0] cur_d   = '0;
  logic         cur_bor = 1'b0;
  logic [W-1:0] m_diff  = '0;
  logic         m_bor   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_diff  <= '0;
      m_bor   <= 1'b0;
    end else if (m_phase == 0 || m_phase == W + 1) begin
      if (bus_if.start_in) begin
        cur_d   <= bus_if.A_in - bus_if.B_in;
        cur_bor <= (bus_if.A_in < bus_if.B_in);
        m_phase <= 1;
      end else begin
        m_phase <= 0;
      end
    end else if (m_phase == W) begin
      m_diff  <= cur_d;
      m_bor   <= cur_bor;
      m_phase <= W + 1;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic running;
      logic exp_bit;
      running = (m_phase >= 1 && m_phase <= W);
      exp_bit = running ? cur_d[m_phase-1] : 1'b0;
      chk("cmp_busy",   32'(bus_if.busy_out),   32'(running));
      chk("cmp_done",   32'(bus_if.done_out),   32'(m_phase == W + 1));
      chk("cmp_bit",    32'(bus_if.Bit_out),    32'(exp_bit));
      chk("cmp_diff",   32'(bus_if.Diff_out),   32'(m_diff));
      chk("cmp_borrow", 32'(bus_if.Borrow_out), 32'(m_bor));
    end
  end

  // ---------------- directed tests ----------------
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_d, input logic exp_b, input string name);
    logic [W-1:0] bits;
    int n;
    int nbusy;
    bit seen;
    bits = '0; n = 0; nbusy = 0; seen = 1'b0;
    @(posedge clk); #1;
    bus_if.A_in = a; bus_if.B_in = b; bus_if.start_in = 1'b1;
    @(posedge clk); #1;
    bus_if.start_in = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (bus_if.busy_out) begin
        nbusy++;
        if (n <= W) bits[n-1] = bus_if.Bit_out;
      end
      if (bus_if.done_out) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_done_cycle"}, 32'(n), 32'd9);
    chk({name, "_busy_cycles"}, 32'(nbusy), 32'd8);
    chk({name, "_serial_bits"}, 32'(bits), 32'(exp_d));
    chk({name, "_diff"}, 32'(bus_if.Diff_out), 32'(exp_d));
    chk({name, "_borrow"}, 32'(bus_if.Borrow_out), 32'(exp_b));
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_busy"},   32'(bus_if.busy_out),   32'd0);
    chk({name, "_done"},   32'(bus_if.done_out),   32'd0);
    chk({name, "_diff"},   32'(bus_if.Diff_out),   32'd0);
    chk({name, "_borrow"}, 32'(bus_if.Borrow_out), 32'd0);
    chk({name, "_bit"},    32'(bus_if.Bit_out),    32'd0);
  endtask

  initial begin
    int ndone;
    int pending;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus_if.start_in = 1'b0;
    bus_if.A_in = '0;
    bus_if.B_in = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    #1 rst_n = 1'b1;

    // Basic and boundary vectors with hand-computed results.
    run_op(8'd5,   8'd3,   8'd2,   1'b0, "a5_b3");
    run_op(8'd3,   8'd5,   8'd254, 1'b1, "a3_b5");
    run_op(8'd0,   8'd0,   8'd0,   1'b0, "a0_b0");
    run_op(8'd255, 8'd255, 8'd0,   1'b0, "a255_b255");
    run_op(8'd0,   8'd1,   8'd255, 1'b1, "a0_b1");
    run_op(8'd128, 8'd1,   8'd127, 1'b0, "a128_b1");

    // Start pulses with new operands during RUN cycles 2 and 5 are ignored.
    @(posedge clk); #1;
    bus_if.A_in = 8'd5; bus_if.B_in = 8'd3; bus_if.start_in = 1'b1;
    @(posedge clk); #1;
    bus_if.start_in = 1'b0;
    ndone = 0;
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      if (bus_if.done_out) begin
        ndone++;
        chk("ignore_done_cycle", 32'(j), 32'd9);
        chk("ignore_diff", 32'(bus_if.Diff_out), 32'd2);
        chk("ignore_borrow", 32'(bus_if.Borrow_out), 32'd0);
      end
      if (j == 2 || j == 5) begin
        bus_if.start_in = 1'b1; bus_if.A_in = 8'd99; bus_if.B_in = 8'd44;
      end else begin
        bus_if.start_in = 1'b0;
      end
    end
    chk("ignore_done_count", 32'(ndone), 32'd1);

    // start held high for 30 cycles: results at cycles 9, 18, 27.
    @(posedge clk); #1;
    bus_if.A_in = 8'd200; bus_if.B_in = 8'd100; bus_if.start_in = 1'b1;
    @(posedge clk);
    ndone = 0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      chk("held_done", 32'(bus_if.done_out), 32'(j == 9 || j == 18 || j == 27));
      chk("held_busy", 32'(bus_if.busy_out), 32'(!(j == 9 || j == 18 || j == 27)));
      if (bus_if.done_out) begin
        ndone++;
        chk("held_diff", 32'(bus_if.Diff_out), 32'd100);
      end
    end
    chk("held_done_count", 32'(ndone), 32'd3);
    bus_if.start_in = 1'b0;
    // The operation started at cycle 27 still completes at cycle 36.
    pending = 0;
    while (!bus_if.done_out && pending < 20) begin
      @(negedge clk);
      pending++;
    end
    chk("held_tail_done", 32'(pending), 32'd6);

    // Asynchronous reset mid-RUN aborts the operation with no done pulse.
    @(posedge clk); #1;
    bus_if.A_in = 8'd77; bus_if.B_in = 8'd20; bus_if.start_in = 1'b1;
    @(posedge clk); #1;
    bus_if.start_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", 32'(bus_if.busy_out), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrun_reset");
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus_if.done_out) ndone++;
    end
    chk("midrun_no_done", 32'(ndone), 32'd0);
    #1 rst_n = 1'b1;
    run_op(8'd10, 8'd7, 8'd3, 1'b0, "after_reset");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
